led_pwm_driver: RTL and testbench
=================================

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, giving the PWM counter and duty width.
REQ-002 The block SHALL have parameter PRESCALE_BITS, default 16, giving the prescaler width.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 led_en  input  1  LED enable level from the upstream PIO output register.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  Avalon-MM write strobe, active low.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 readdata  output  32  Avalon-MM read data, combinational, zero-wait.
REQ-011 led_out  output  1  registered drive to the physical LED pin.

Function
REQ-012 A write SHALL occur when chipselect=1 and write_n=0; register map: 0 DUTY[PWM_BITS-1:0] (shadow), 1 PRESCALE[PRESCALE_BITS-1:0], 2 BLINK_HALF[15:0], 3 STATUS (read-only, writes ignored).
REQ-013 readdata SHALL return the addressed register zero-extended; STATUS = {29'b0, state[1:0], led_out}; unimplemented bits and addresses SHALL read 0.
REQ-014 The state machine SHALL have states IDLE=0, RUN=1 and DARK=2.
REQ-015 IDLE->RUN on led_en=1; RUN or DARK->IDLE on led_en=0; the transition SHALL take effect on the next clk edge.
REQ-016 In IDLE the prescaler, PWM counter and blink counter SHALL be held at 0, and led_out SHALL be 0 one cycle after entry.
REQ-017 In RUN/DARK the prescaler SHALL count 0..PRESCALE, assert a one-cycle tick when equal to PRESCALE, and wrap to 0 on that cycle; PRESCALE=0 SHALL tick every cycle.
REQ-018 The PWM counter SHALL increment on tick and wrap from 2^PWM_BITS-1 to 0; the cycle of that wrap is the period end.
REQ-019 On IDLE->RUN the active duty SHALL be loaded from DUTY.
REQ-020 At each period end the active duty SHALL be reloaded from DUTY; a DUTY write coincident with a period end SHALL load the new writedata directly.
REQ-021 The next-state value of led_out in RUN SHALL be 1 when active duty = 2^PWM_BITS-1 (full on) or PWM counter < active duty, else 0; active duty 0 SHALL give constant 0.
REQ-022 In DARK the next-state value of led_out SHALL be 0 while all counters keep running.
REQ-023 led_out SHALL lag the compare inputs by exactly one clk.
REQ-024 A PRESCALE write SHALL clear the prescaler counter on the same edge.

Reset
REQ-025 While reset=1 at a clk edge, DUTY, active duty, PRESCALE, BLINK_HALF, all counters and led_out SHALL become 0 and state SHALL become IDLE, overriding any coincident write or led_en.
REQ-026 Reset asserted mid-period or in DARK SHALL give led_out=0 on the first edge after assertion and IDLE behaviour on release.

Configuration
REQ-027 Macro LED_PWM_BLINK_EN SHALL compile the blink feature in.
REQ-028 With LED_PWM_BLINK_EN defined: when BLINK_HALF≠0, a blink counter SHALL count period ends; after BLINK_HALF period ends it SHALL clear and the state SHALL toggle RUN<->DARK; BLINK_HALF=0 SHALL force RUN; a BLINK_HALF write SHALL clear the blink counter and return DARK to RUN.
REQ-029 Without LED_PWM_BLINK_EN: no BLINK_HALF register or blink counter SHALL exist; address 2 SHALL read 0 and ignore writes; DARK SHALL be unreachable.

Verification
REQ-030 Reset, led_en=1, DUTY=64, PRESCALE=0 -> led_out high for exactly 64 of every 256 cycles, first rise 2 cycles after led_en.
REQ-031 RUN with DUTY=64; write DUTY=192 mid-period -> current period keeps 64 high cycles; next period has 192.
REQ-032 DUTY=0 and then DUTY=255 -> led_out constant 0, then constant 1 from the next period onward.
REQ-033 PRESCALE=3, DUTY=128 -> period 1024 cycles, 512 high; led_en=0 mid-period -> led_out 0 within 2 cycles, STATUS reads 0.
REQ-034 With LED_PWM_BLINK_EN defined, PRESCALE=0, DUTY=255, BLINK_HALF=2 -> 512 cycles on, 512 off, repeating; STATUS state field alternates 1/2.
REQ-035 Reset pulsed during DARK with DUTY=100 -> all registers read 0, led_out 0, state IDLE.

Source files
------------

// File: rtl/led_pwm_driver.sv
// PWM LED driver with an Avalon-MM register file and an IDLE/RUN/DARK state machine.
// Define LED_PWM_BLINK_EN to build in the BLINK_HALF register and the RUN<->DARK blink counter.
module led_pwm_driver #(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        led_en,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        led_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DARK = 2'd2} state_t;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  state_t                   state_reg, state_next;
  logic [PWM_BITS-1:0]      duty_reg, duty_next;
  logic [PWM_BITS-1:0]      active_reg, active_next;
  logic [PWM_BITS-1:0]      pwm_cnt_reg, pwm_cnt_next;
  logic [PRESCALE_BITS-1:0] prescale_reg, prescale_next;
  logic [PRESCALE_BITS-1:0] presc_cnt_reg, presc_cnt_next;
  logic                     led_reg, led_next;
  logic                     wr, tick, period_end;
  logic                     blink_toggle, blink_force_run;
  logic [31:0]              blink_rd;
  logic                     unused_bits;

  assign wr          = chipselect & ~write_n;
  assign tick        = (state_reg != IDLE) && (presc_cnt_reg == prescale_reg);
  assign period_end  = tick && (pwm_cnt_reg == PWM_MAX);
  assign unused_bits = ^writedata;

`ifdef LED_PWM_BLINK_EN
  logic [15:0] blink_half_reg, blink_half_next;
  logic [15:0] blink_cnt_reg, blink_cnt_next;
  logic        blink_wr;

  assign blink_wr        = wr && (address == 2'd2);
  assign blink_force_run = blink_wr || (blink_half_reg == 16'd0);
  assign blink_rd        = {16'd0, blink_half_reg};

  always_comb begin
    blink_half_next = blink_wr ? writedata[15:0] : blink_half_reg;
    blink_cnt_next  = blink_cnt_reg;
    blink_toggle    = 1'b0;
    if (state_reg == IDLE || blink_wr || blink_half_reg == 16'd0) begin
      blink_cnt_next = 16'd0;
    end else if (period_end) begin
      if (blink_cnt_reg + 16'd1 == blink_half_reg) begin
        blink_cnt_next = 16'd0;
        blink_toggle   = 1'b1;
      end else begin
        blink_cnt_next = blink_cnt_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_half_reg <= 16'd0;
      blink_cnt_reg  <= 16'd0;
    end else begin
      blink_half_reg <= blink_half_next;
      blink_cnt_reg  <= blink_cnt_next;
    end
  end
`else
  assign blink_toggle    = 1'b0;
  assign blink_force_run = 1'b1;
  assign blink_rd        = 32'd0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (led_en) state_next = RUN;
      RUN: begin
        if (!led_en)           state_next = IDLE;
        else if (blink_toggle) state_next = DARK;
      end
      DARK: begin
        if (!led_en)                              state_next = IDLE;
        else if (blink_force_run || blink_toggle) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // A DUTY write landing on a reload edge is picked up directly through duty_next.
  always_comb begin
    duty_next      = (wr && address == 2'd0) ? writedata[PWM_BITS-1:0] : duty_reg;
    prescale_next  = (wr && address == 2'd1) ? writedata[PRESCALE_BITS-1:0] : prescale_reg;
    presc_cnt_next = presc_cnt_reg;
    pwm_cnt_next   = pwm_cnt_reg;
    active_next    = active_reg;
    led_next       = 1'b0;
    if (state_reg == IDLE) begin
      presc_cnt_next = '0;
      pwm_cnt_next   = '0;
      if (led_en) active_next = duty_next;
    end else begin
      if ((wr && address == 2'd1) || tick) presc_cnt_next = '0;
      else                                 presc_cnt_next = presc_cnt_reg + 1'b1;
      if (tick)       pwm_cnt_next = pwm_cnt_reg + 1'b1;
      if (period_end) active_next  = duty_next;
    end
    if (state_reg == RUN)
      led_next = (active_reg == PWM_MAX) || (pwm_cnt_reg < active_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      duty_reg      <= '0;
      active_reg    <= '0;
      pwm_cnt_reg   <= '0;
      prescale_reg  <= '0;
      presc_cnt_reg <= '0;
      led_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      duty_reg      <= duty_next;
      active_reg    <= active_next;
      pwm_cnt_reg   <= pwm_cnt_next;
      prescale_reg  <= prescale_next;
      presc_cnt_reg <= presc_cnt_next;
      led_reg       <= led_next;
    end
  end

  assign led_out = led_reg;

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata[PWM_BITS-1:0]      = duty_reg;
      2'd1:    readdata[PRESCALE_BITS-1:0] = prescale_reg;
      2'd2:    readdata                    = blink_rd;
      default: readdata[2:0]               = {state_reg, led_reg};
    endcase
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed self-checking bench for led_pwm_driver: duty, prescale, shadow reload, disable,
// blink (when LED_PWM_BLINK_EN is defined) and reset behaviour.
module tb_led_pwm_driver;
  logic        clk = 1'b0;
  logic        reset, led_en, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        led_out;
  int          checks = 0;
  int          errors = 0;
  int          hi;

  always #5 clk = ~clk;

  led_pwm_driver #(.PWM_BITS(8), .PRESCALE_BITS(16)) dut (
    .clk(clk), .reset(reset), .led_en(led_en), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .led_out(led_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    $display("write addr=%0d data=%0d", a, d);
  endtask

  task automatic read_check(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a; #1;
    $display("read  addr=%0d data=%0d", a, readdata);
    check(tag, readdata, exp);
    address = 2'd0;
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (led_out === 1'b1) cnt++;
    end
    $display("window %0d cycles: led high %0d", n, cnt);
  endtask

  initial begin
    reset = 1'b1; led_en = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_led", {31'd0, led_out}, 32'd0);
    read_check(2'd0, 32'd0, "reset_duty");
    read_check(2'd1, 32'd0, "reset_prescale");
    read_check(2'd2, 32'd0, "reset_blink");
    read_check(2'd3, 32'd0, "reset_status");

    // DUTY=64, PRESCALE=0: first rise on second edge, 64 of 256 high
    bus_write(2'd0, 32'd64);
    led_en = 1'b1;
    @(posedge clk); #1;
    check("run_entry_led", {31'd0, led_out}, 32'd0);
    read_check(2'd3, 32'd2, "run_entry_status");
    @(posedge clk); #1;
    check("first_rise", {31'd0, led_out}, 32'd1);
    count_high(256, hi);
    check("duty64_period", hi, 32'd64);

    // mid-period DUTY=192: current period keeps 64, next gets 192
    count_high(100, hi);
    check("duty64_partial", hi, 32'd63);
    bus_write(2'd0, 32'd192);
    count_high(154, hi);
    check("shadow_hold", hi, 32'd0);
    count_high(256, hi);
    check("duty192_period", hi, 32'd192);
    read_check(2'd0, 32'd192, "duty_readback");

    // DUTY=0 then DUTY=255
    bus_write(2'd0, 32'd0);
    count_high(255, hi);
    check("duty192_tail", hi, 32'd191);
    count_high(256, hi);
    check("duty0_period", hi, 32'd0);
    bus_write(2'd0, 32'd255);
    count_high(255, hi);
    check("duty0_tail", hi, 32'd0);
    count_high(256, hi);
    check("duty255_period", hi, 32'd256);

    // PRESCALE=3, DUTY=128: 1024-cycle period, 512 high
    led_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    read_check(2'd3, 32'd0, "disabled_status");
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'd128);
    led_en = 1'b1;
    @(posedge clk); #1;
    count_high(1024, hi);
    check("presc3_period1", hi, 32'd512);
    count_high(1024, hi);
    check("presc3_period2", hi, 32'd512);
    count_high(100, hi);
    check("presc3_mid_led", {31'd0, led_out}, 32'd1);
    read_check(2'd1, 32'd3, "prescale_readback");
    led_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("disable_led", {31'd0, led_out}, 32'd0);
    read_check(2'd3, 32'd0, "disable_status");

`ifdef LED_PWM_BLINK_EN
    // blink: 512 on, 512 off with PRESCALE=0, DUTY=255, BLINK_HALF=2
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'd255);
    bus_write(2'd2, 32'd2);
    read_check(2'd2, 32'd2, "blink_readback");
    led_en = 1'b1;
    @(posedge clk); #1;
    count_high(512, hi);
    check("blink_on1", hi, 32'd512);
    read_check(2'd3, 32'd5, "blink_status_dark");
    count_high(512, hi);
    check("blink_off1", hi, 32'd0);
    read_check(2'd3, 32'd2, "blink_status_run");
    count_high(512, hi);
    check("blink_on2", hi, 32'd512);
    count_high(10, hi);
    check("blink_dark_led", hi, 32'd0);
    bus_write(2'd0, 32'd100);
    read_check(2'd3, 32'd4, "pre_reset_dark");
`else
    // address 2 is unimplemented: writes ignored, reads 0
    bus_write(2'd2, 32'd5);
    read_check(2'd2, 32'd0, "addr2_reads_zero");
    bus_write(2'd0, 32'd100);
    led_en = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("pre_reset_led", {31'd0, led_out}, 32'd1);
`endif

    // reset pulse in the middle of activity
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_pulse_led", {31'd0, led_out}, 32'd0);
    read_check(2'd0, 32'd0, "reset_pulse_duty");
    read_check(2'd1, 32'd0, "reset_pulse_prescale");
    read_check(2'd2, 32'd0, "reset_pulse_blink");
    read_check(2'd3, 32'd0, "reset_pulse_status");
    reset = 1'b0;
    led_en = 1'b0;
    @(posedge clk); #1;
    read_check(2'd3, 32'd0, "post_reset_status");
    check("post_reset_led", {31'd0, led_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
